// File: rtl/io_handshake_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// io_handshake_ctrl_pkg
//   Shared definitions for the IN/OUT stall-handshake responder.
//   - io_state_t               : handshake FSM state (2-bit encoding)
//   - DEFAULT_DEBOUNCE_CYCLES  : default stable-sample count for the confirm button
// ----------------------------------------------------------------------------
package io_handshake_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IN  = 2'd1,
    WAIT_OUT = 2'd2,
    ACK      = 2'd3
  } io_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;

endpackage

// File: rtl/io_handshake_ctrl_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
//   Synchronises a raw asynchronous push button, filters contact bounce, and
//   produces a one-cycle pulse when the filtered level rises.
//
//   Ports
//     clock      in   system clock, rising edge
//     reset      in   synchronous, active-high
//     btn_raw    in   raw asynchronous button, active-high
//     btn_level  out  debounced level
//     btn_pulse  out  one-cycle pulse on a debounced 0->1 transition
//
//   The filtered level follows the synchronised input only after
//   DEBOUNCE_CYCLES consecutive samples that disagree with the current level.
//   A held button therefore yields one pulse; it must be seen released before
//   another press can pulse again.
// ----------------------------------------------------------------------------
module button_debounce
  import io_handshake_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES  // must be >= 2
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] stable_cnt;

  // stable_cnt counts consecutive synchronised samples that differ from the
  // accepted level; the sample that would make it reach DEBOUNCE_CYCLES flips
  // the level instead.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta  <= 1'b0;
      sync_q     <= 1'b0;
      btn_level  <= 1'b0;
      btn_pulse  <= 1'b0;
      stable_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge
      // value; blocking here would collapse the two synchroniser stages.
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
      btn_pulse <= 1'b0;
      if (sync_q == btn_level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_MAX) begin
        btn_level  <= sync_q;
        btn_pulse  <= sync_q;  // only a rise produces a pulse
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_handshake_ctrl.sv
// ----------------------------------------------------------------------------
// io_handshake_ctrl
//   Responder side of the control unit's IN/OUT stall handshake. Latches the
//   register value for OUT onto the display, captures (extended) switch input
//   for IN, and returns a one-cycle 'sinal' acknowledge once the operator
//   presses the confirm button.
//
//   Ports
//     clock        in   system clock, rising edge
//     reset        in   synchronous, active-high
//     in_req       in   control unit "in" request
//     out_req      in   control unit "out" request
//     stop         in   control unit stall flag; requests are valid only with it
//     data_out     in   [DATA_WIDTH] register value to show for OUT
//     switches     in   [SW_WIDTH]   raw, quasi-static switch inputs
//     confirm_btn  in   raw asynchronous confirm button, active-high
//     sinal        out  acknowledge pulse to the control unit (registered)
//     data_in      out  [DATA_WIDTH] extended switch value for IN write-back
//     display      out  [DATA_WIDTH] last OUT value, held until the next OUT
//     waiting_in   out  LED: awaiting input confirm
//     waiting_out  out  LED: awaiting display confirm
//
//   DATA_WIDTH must exceed SW_WIDTH.
// ----------------------------------------------------------------------------
module io_handshake_ctrl
  import io_handshake_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int SW_WIDTH        = 16,
  parameter bit SIGN_EXTEND     = 1'b0,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_req,
  input  logic                  out_req,
  input  logic                  stop,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic [SW_WIDTH-1:0]   switches,
  input  logic                  confirm_btn,
  output logic                  sinal,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] display,
  output logic                  waiting_in,
  output logic                  waiting_out
);

  io_state_t             state;
  io_state_t             next_state;
  logic                  confirm_pulse;
  logic                  confirm_level;
  logic                  sign_fill;
  logic [DATA_WIDTH-1:0] sw_ext;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_confirm (
    .clock     (clock),
    .reset     (reset),
    .btn_raw   (confirm_btn),
    .btn_level (confirm_level),
    .btn_pulse (confirm_pulse)
  );

  // The level itself is only needed inside the debouncer.
  logic unused_level;
  assign unused_level = confirm_level;

  assign sign_fill = SIGN_EXTEND & switches[SW_WIDTH-1];
  assign sw_ext    = {{(DATA_WIDTH - SW_WIDTH){sign_fill}}, switches};

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic. Requests are sampled only in IDLE; in_req wins when both
  // are raised. A request dropped while waiting does not abort the wait.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // next_state unassigned, which would infer a latch.
    next_state = state;
    unique case (state)
      IDLE: begin
        if (stop && in_req)       next_state = WAIT_IN;
        else if (stop && out_req) next_state = WAIT_OUT;
      end
      WAIT_IN:  if (confirm_pulse) next_state = ACK;
      WAIT_OUT: if (confirm_pulse) next_state = ACK;
      ACK:      next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Output decode for the status LEDs
  always_comb begin
    waiting_in  = (state == WAIT_IN);
    waiting_out = (state == WAIT_OUT);
  end

  // Registered outputs. sinal is a flop loaded from next_state so it is high
  // exactly while the FSM sits in ACK, without decode glitches.
  always_ff @(posedge clock) begin
    if (reset) begin
      sinal   <= 1'b0;
      data_in <= '0;
      display <= '0;
    end else begin
      sinal <= (next_state == ACK);
      if (state == IDLE && stop && out_req && !in_req) display <= data_out;
      if (state == WAIT_IN && confirm_pulse)            data_in <= sw_ext;
    end
  end

endmodule
